adder_vector_sequencer: RTL and testbench

//  Clocked stimulus source feeding the 2-bit adder comparison harness (Top/Golden/Taupe).

---
 rtl/adder_tb_pkg.sv | 34 +++
 rtl/vec_lfsr.sv | 40 ++++
 rtl/adder_vector_sequencer.sv | 120 ++++++++++++
 tb/tb_adder_vector_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_tb_pkg.sv
// Shared types and LFSR helpers for the adder-harness vector sequencer.
// LFSR widths 3/5/7/9 cover operand widths 1..4.
package adder_tb_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_e;

    // Tap masks for maximal-length Fibonacci LFSRs; tap n is bit n-1.
    localparam logic [8:0] TapsVw3 = 9'b0_0000_0110;
    localparam logic [8:0] TapsVw5 = 9'b0_0001_0100;
    localparam logic [8:0] TapsVw7 = 9'b0_0110_0000;
    localparam logic [8:0] TapsVw9 = 9'b1_0001_0000;

    function automatic int unsigned vw(input int unsigned width);
        return 2 * width + 1;
    endfunction

    function automatic logic [8:0] lfsr_taps(input int unsigned w);
        case (w)
            3:       return TapsVw3;
            5:       return TapsVw5;
            7:       return TapsVw7;
            default: return TapsVw9;
        endcase
    endfunction

    function automatic logic [8:0] lfsr_next(input logic [8:0] vec, input int unsigned w);
        logic [8:0] mask;
        logic       fb;
        mask = 9'h1ff >> (9 - w);
        fb   = ^(vec & lfsr_taps(w));
        return {vec[7:0], fb} & mask;
    endfunction

endpackage

// File: rtl/vec_lfsr.sv
// VW-bit Fibonacci LFSR step register with zero-load, seed-load and step enables.
module vec_lfsr
    import adder_tb_pkg::*;
#(
    parameter int unsigned VW = 5
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_zero_i,
    input  logic          load_seed_i,
    input  logic          step_i,
    output logic [VW-1:0] vec_o
);

    logic [VW-1:0] vec_q, vec_d;
    logic [8:0]    step_val;

    always_comb begin
        step_val = lfsr_next(9'(vec_q), VW);
        vec_d    = vec_q;
        if (load_zero_i) begin
            vec_d = '0;
        end else if (load_seed_i) begin
            vec_d = VW'(1);
        end else if (step_i) begin
            vec_d = VW'(step_val);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vec_q <= '0;
        end else begin
            vec_q <= vec_d;
        end
    end

    assign vec_o = vec_q;

endmodule

// File: rtl/adder_vector_sequencer.sv
// Clocked stimulus source for the 2-bit adder harness: walks every {a,b,cin}
// vector in ascending or LFSR order, holding each for SETTLE cycles.
module adder_vector_sequencer
    import adder_tb_pkg::*;
#(
    parameter int unsigned  WIDTH  = 2,
    parameter int unsigned  SETTLE = 2,
    localparam int unsigned VW     = vw(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pause,
    input  logic             mode_rand,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             cin,
    output logic             vec_valid,
    output logic [VW-1:0]    vec_index,
    output logic             busy,
    output logic             done
);

    localparam int unsigned   CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] HoldLast = CW'(SETTLE - 1);
    localparam logic [VW-1:0] IdxLast  = '1;

    state_e        state_q, state_d;
    logic [VW-1:0] vec_index_q, vec_index_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic          mode_q, mode_d;
    logic          load_zero, load_seed, step;
    logic          last_hold;
    logic [VW-1:0] lfsr_vec, vec_cur;

    vec_lfsr #(
        .VW (VW)
    ) u_vec_lfsr (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .load_zero_i (load_zero),
        .load_seed_i (load_seed),
        .step_i      (step),
        .vec_o       (lfsr_vec)
    );

    assign last_hold = (hold_cnt_q == HoldLast);

    always_comb begin
        state_d     = state_q;
        vec_index_d = vec_index_q;
        hold_cnt_d  = hold_cnt_q;
        mode_d      = mode_q;
        load_zero   = 1'b0;
        load_seed   = 1'b0;
        step        = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = DRIVE;
                    vec_index_d = '0;
                    hold_cnt_d  = '0;
                    mode_d      = mode_rand;
                    load_zero   = 1'b1;
                end
            end
            DRIVE: begin
                if (!pause) begin
                    if (last_hold) begin
                        hold_cnt_d = '0;
                        if (vec_index_q == IdxLast) begin
                            state_d = DONE;
                        end else begin
                            vec_index_d = vec_index_q + VW'(1);
                            // Index 0 is the all-zero vector; the LFSR proper starts at the seed.
                            if (vec_index_q == '0) begin
                                load_seed = 1'b1;
                            end else begin
                                step = 1'b1;
                            end
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_index_q <= '0;
            hold_cnt_q  <= '0;
            mode_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_index_q <= vec_index_d;
            hold_cnt_q  <= hold_cnt_d;
            mode_q      <= mode_d;
        end
    end

    always_comb begin
        vec_cur = mode_q ? lfsr_vec : vec_index_q;
        if (state_q != DRIVE) begin
            vec_cur = '0;
        end
    end

    assign a         = vec_cur[VW-1 -: WIDTH];
    assign b         = vec_cur[WIDTH:1];
    assign cin       = vec_cur[0];
    assign busy      = (state_q == DRIVE);
    assign done      = (state_q == DONE);
    assign vec_index = vec_index_q;
    assign vec_valid = busy && !pause && last_hold;

endmodule

// File: tb/tb_adder_vector_sequencer.sv
// Scoreboard bench for adder_vector_sequencer: WIDTH=2/SETTLE=2 and WIDTH=1/SETTLE=1 instances.
module tb_adder_vector_sequencer;

    localparam int N0 = 32;
    localparam int S0 = 2;
    localparam int N1 = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0, pause0 = 1'b0, mode0 = 1'b0;
    logic [1:0] a0, b0;
    logic       cin0, valid0, busy0, done0;
    logic [4:0] idx0, abc0;
    logic       start1 = 1'b0, pause1 = 1'b0, mode1 = 1'b0;
    logic [0:0] a1, b1;
    logic       cin1, valid1, busy1, done1;
    logic [2:0] idx1, abc1;

    typedef struct {
        int idx;
        int vec;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    assign abc0 = {a0, b0, cin0};
    assign abc1 = {a1, b1, cin1};

    always #5 clk = ~clk;

    adder_vector_sequencer #(
        .WIDTH  (2),
        .SETTLE (2)
    ) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start0),
        .pause     (pause0),
        .mode_rand (mode0),
        .a         (a0),
        .b         (b0),
        .cin       (cin0),
        .vec_valid (valid0),
        .vec_index (idx0),
        .busy      (busy0),
        .done      (done0)
    );

    adder_vector_sequencer #(
        .WIDTH  (1),
        .SETTLE (1)
    ) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .pause     (pause1),
        .mode_rand (mode1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .vec_valid (valid1),
        .vec_index (idx1),
        .busy      (busy1),
        .done      (done1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Independent reference: ascending index, or 0, seed 1, then Fibonacci steps.
    function automatic int model_vec(input bit rnd, input int idx, input int vwid);
        int v;
        bit fb;
        if (!rnd || idx == 0) return idx;
        v = 1;
        for (int i = 1; i < idx; i++) begin
            fb = (vwid == 5) ? (v[4] ^ v[2]) : (v[2] ^ v[1]);
            v  = ((v << 1) | int'(fb)) & ((1 << vwid) - 1);
        end
        return v;
    endfunction

    task automatic run0(input bit rnd, input int pause_idx, input int pause_len,
                        input int restart_idx);
        int          k;
        int          pulses;
        int          pcnt;
        bit          restarted;
        logic [31:0] seen;
        int          first[4];
        exp_t        e;
        for (int i = 0; i < N0; i++) sb_q.push_back('{idx: i, vec: model_vec(rnd, i, 5)});
        pulses    = 0;
        pcnt      = 0;
        restarted = 1'b0;
        seen      = '0;
        @(negedge clk);
        start0 = 1'b1;
        mode0  = rnd;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            start0 = 1'b0;
            if (k == 0) mode0 = ~rnd;
            pause0 = (pause_len > 0 && int'(idx0) == pause_idx && pcnt < pause_len);
            if (pause0) pcnt++;
            if (!restarted && restart_idx >= 0 && int'(idx0) == restart_idx) begin
                start0    = 1'b1;
                restarted = 1'b1;
            end
            #1;
            if (k == 0) begin
                check_eq("start_busy", busy0, 1);
                check_eq("start_done", done0, 0);
                check_eq("start_idx", idx0, 0);
                check_eq("start_vec", abc0, 0);
            end
            if (done0) break;
            if (pause0) begin
                check_eq("pause_valid", valid0, 0);
                check_eq("pause_idx", idx0, pause_idx);
                check_eq("pause_vec", abc0, model_vec(rnd, pause_idx, 5));
            end
            if (valid0) begin
                if (sb_q.size() == 0) begin
                    check_eq("extra_pulse", pulses + 1, N0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("pulse_idx", idx0, e.idx);
                    check_eq("pulse_vec", abc0, e.vec);
                end
                if (pulses < 4) first[pulses] = int'(abc0);
                seen[abc0] = 1'b1;
                pulses++;
            end
        end
        pause0 = 1'b0;
        start0 = 1'b0;
        check_eq("done_cycles", k, N0 * S0 + pause_len);
        check_eq("pulse_count", pulses, N0);
        check_eq("sb_empty", sb_q.size(), 0);
        check_eq("end_busy", busy0, 0);
        check_eq("end_done", done0, 1);
        check_eq("end_vec", abc0, 0);
        if (rnd) begin
            check_eq("distinct", $countones(seen), N0);
            check_eq("rnd_v0", first[0], 0);
            check_eq("rnd_v1", first[1], 1);
            check_eq("rnd_v2", first[2], 2);
            check_eq("rnd_v3", first[3], 4);
        end
        sb_q.delete();
    endtask

    initial begin
        int k;
        #1;
        check_eq("rst_busy", busy0, 0);
        check_eq("rst_done", done0, 0);
        check_eq("rst_idx", idx0, 0);
        check_eq("rst_vec", abc0, 0);
        check_eq("rst_valid", valid0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("idle_busy", busy0, 0);

        run0(1'b0, -1, 0, -1);   // exhaustive
        run0(1'b1, -1, 0, -1);   // LFSR order
        run0(1'b0, 7, 5, -1);    // pause during vector 7
        run0(1'b0, -1, 0, 10);   // start re-pulsed mid-run

        repeat (3) @(negedge clk);
        #1;
        check_eq("done_held", done0, 1);
        check_eq("done_busy", busy0, 0);
        run0(1'b1, -1, 0, -1);   // restart from DONE

        // Asynchronous reset in the middle of vector 12.
        @(negedge clk);
        start0 = 1'b1;
        mode0  = 1'b0;
        @(negedge clk);
        start0 = 1'b0;
        for (int i = 0; i < 100 && idx0 != 5'd12; i++) @(negedge clk);
        check_eq("reach_12", idx0, 12);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_vec", abc0, 0);
        check_eq("arst_idx", idx0, 0);
        check_eq("arst_valid", valid0, 0);
        check_eq("arst_busy", busy0, 0);
        check_eq("arst_done", done0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check_eq("post_busy", busy0, 0);
        check_eq("post_done", done0, 0);
        check_eq("post_idx", idx0, 0);

        // SETTLE=1, WIDTH=1: one valid vector per cycle.
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (k = 0; k < 20; k++) begin
            #1;
            if (done1) break;
            check_eq("s1_valid", valid1, 1);
            check_eq("s1_idx", idx1, k);
            check_eq("s1_vec", abc1, model_vec(1'b0, k, 3));
            @(negedge clk);
        end
        check_eq("s1_done_cycles", k, N1);
        check_eq("s1_busy", busy1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
